ram_arbiter2: RTL and testbench

- Two-requester arbiter that shares the single-port 4k x 32 on-chip RAM between the CPU instruction bus (I) and data bus (D).
- Accepts at most one command per cycle and drives the RAM ADR/D/WEM/WE/ME/OE pins.
- Returns read data exactly one cycle after grant, routed to the requester that issued the read.
- Sits between the VexRiscv bus adapters and the RAM macro.

---
 rtl/ram_arbiter2_pkg.sv | 14 +
 rtl/ram_arbiter2_arb2_rr.sv | 60 ++++++
 rtl/ram_arbiter2.sv | 91 +++++++++
 tb/tb_ram_arbiter2.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter2_pkg.sv
// Shared types for the I/D RAM arbiter: requester identity and the read-response tag.
package ram_arbiter2_pkg;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic   vld;
    owner_e own;
  } rsp_tag_t;

endpackage

// File: rtl/ram_arbiter2_arb2_rr.sv
// Two-way picker: round-robin, or D-first with a starvation counter that force-grants I.
module arb2_rr
  import ram_arbiter2_pkg::*;
#(
  parameter int FIXED_PRI = 0,
  parameter int MAX_WAIT  = 7
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  owner_e     rr_last_r;
  logic [7:0] wait_cnt_r;

  // Grant selection; bit 0 is I, bit 1 is D
  always_comb begin
    gnt = 2'b00;
    if (!grant_en) begin
      gnt = 2'b00;
    end else begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          if (FIXED_PRI != 0) begin
            gnt = (wait_cnt_r == MAX_WAIT_C) ? 2'b01 : 2'b10;
          end else begin
            gnt = (rr_last_r == OWN_I) ? 2'b10 : 2'b01;
          end
        end
        default: gnt = 2'b00;
      endcase
    end
  end

  // Arbitration history: last winner and how long I has been kept waiting
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_last_r  <= OWN_I;
      wait_cnt_r <= 8'd0;
    end else begin
      if (gnt != 2'b00) begin
        rr_last_r <= gnt[1] ? OWN_D : OWN_I;
      end
      if (req[0] && !gnt[0]) begin
        if (wait_cnt_r != MAX_WAIT_C) begin
          wait_cnt_r <= wait_cnt_r + 8'd1;
        end
      end else begin
        wait_cnt_r <= 8'd0;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter2.sv
// Shares a single-port RAM between the CPU I and D buses; reads return one cycle after grant.
module ram_arbiter2
  import ram_arbiter2_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int FIXED_PRI = 0,
  parameter int MAX_WAIT  = 7
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                i_cmd_valid,
  output logic                i_cmd_ready,
  input  logic [ADDR_W-1:0]   i_cmd_addr,
  output logic                i_rsp_valid,
  output logic [DATA_W-1:0]   i_rsp_data,
  input  logic                d_cmd_valid,
  output logic                d_cmd_ready,
  input  logic                d_cmd_we,
  input  logic [ADDR_W-1:0]   d_cmd_addr,
  input  logic [DATA_W-1:0]   d_cmd_wdata,
  input  logic [DATA_W/8-1:0] d_cmd_wmask,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic [ADDR_W-1:0]   ram_adr,
  output logic [DATA_W-1:0]   ram_d,
  output logic [DATA_W/8-1:0] ram_wem,
  output logic                ram_we,
  output logic                ram_me,
  output logic                ram_oe,
  input  logic [DATA_W-1:0]   ram_q
);

  logic [1:0] req_s;
  logic [1:0] gnt_s;
  rsp_tag_t   tag_r;

  assign req_s = {d_cmd_valid, i_cmd_valid};

  arb2_rr #(
    .FIXED_PRI (FIXED_PRI),
    .MAX_WAIT  (MAX_WAIT)
  ) u_arb (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .req      (req_s),
    .grant_en (1'b1),
    .gnt      (gnt_s)
  );

  assign i_cmd_ready = gnt_s[0];
  assign d_cmd_ready = gnt_s[1];

  // RAM pin drive from the granted command; idle pins go to zero
  always_comb begin
    ram_me  = 1'b0;
    ram_we  = 1'b0;
    ram_adr = '0;
    ram_d   = '0;
    ram_wem = '0;
    if (gnt_s[1]) begin
      ram_me  = 1'b1;
      ram_we  = d_cmd_we;
      ram_adr = d_cmd_addr;
      ram_d   = d_cmd_wdata;
      ram_wem = d_cmd_wmask;
    end else if (gnt_s[0]) begin
      ram_me  = 1'b1;
      ram_adr = i_cmd_addr;
    end else begin
      ram_me  = 1'b0;
    end
  end

  // Tag only reads so writes complete silently at grant
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tag_r <= '0;
    end else begin
      tag_r.vld <= gnt_s[0] | (gnt_s[1] & ~d_cmd_we);
      tag_r.own <= gnt_s[1] ? OWN_D : OWN_I;
    end
  end

  assign i_rsp_valid = tag_r.vld && (tag_r.own == OWN_I);
  assign d_rsp_valid = tag_r.vld && (tag_r.own == OWN_D);
  assign i_rsp_data  = ram_q;
  assign d_rsp_data  = ram_q;
  assign ram_oe      = 1'b1;

endmodule

// File: tb/tb_ram_arbiter2.sv
// Directed bench: round-robin instance with a RAM model, plus a fixed-priority instance for starvation.
module tb_ram_arbiter2;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  // Instance A: round-robin, backed by a behavioural RAM
  logic        a_iv, a_ir, a_irv, a_dv, a_dr, a_dwe, a_drv;
  logic [11:0] a_ia, a_da;
  logic [31:0] a_ird, a_dwd, a_drd;
  logic [3:0]  a_dm;
  logic [11:0] a_ram_adr;
  logic [31:0] a_ram_d, a_ram_q;
  logic [3:0]  a_ram_wem;
  logic        a_ram_we, a_ram_me, a_ram_oe;
  logic [31:0] mem [0:4095];

  ram_arbiter2 u_rr (
    .CLK(CLK), .RST_N(RST_N),
    .i_cmd_valid(a_iv), .i_cmd_ready(a_ir), .i_cmd_addr(a_ia),
    .i_rsp_valid(a_irv), .i_rsp_data(a_ird),
    .d_cmd_valid(a_dv), .d_cmd_ready(a_dr), .d_cmd_we(a_dwe), .d_cmd_addr(a_da),
    .d_cmd_wdata(a_dwd), .d_cmd_wmask(a_dm),
    .d_rsp_valid(a_drv), .d_rsp_data(a_drd),
    .ram_adr(a_ram_adr), .ram_d(a_ram_d), .ram_wem(a_ram_wem),
    .ram_we(a_ram_we), .ram_me(a_ram_me), .ram_oe(a_ram_oe), .ram_q(a_ram_q)
  );

  // Single-port RAM: Q registers the pre-write content of the addressed word
  always @(posedge CLK) begin
    if (a_ram_me) begin
      a_ram_q <= mem[a_ram_adr];
      if (a_ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (a_ram_wem[b]) mem[a_ram_adr][8*b +: 8] <= a_ram_d[8*b +: 8];
        end
      end
    end
  end

  // Instance B: fixed priority with a short starvation limit
  logic        b_iv, b_ir, b_irv, b_dv, b_dr, b_drv;
  logic [31:0] b_ird, b_drd, b_ram_d;
  logic [11:0] b_ram_adr;
  logic [3:0]  b_ram_wem;
  logic        b_ram_we, b_ram_me, b_ram_oe;
  logic [31:0] b_ram_q = 32'h0;
  logic [11:0] b_addr = 12'h0;
  logic [31:0] b_wd = 32'h0;
  logic [3:0]  b_wm = 4'h0;
  logic        b_we = 1'b0;

  ram_arbiter2 #(.FIXED_PRI(1), .MAX_WAIT(3)) u_fp (
    .CLK(CLK), .RST_N(RST_N),
    .i_cmd_valid(b_iv), .i_cmd_ready(b_ir), .i_cmd_addr(b_addr),
    .i_rsp_valid(b_irv), .i_rsp_data(b_ird),
    .d_cmd_valid(b_dv), .d_cmd_ready(b_dr), .d_cmd_we(b_we), .d_cmd_addr(b_addr),
    .d_cmd_wdata(b_wd), .d_cmd_wmask(b_wm),
    .d_rsp_valid(b_drv), .d_rsp_data(b_drd),
    .ram_adr(b_ram_adr), .ram_d(b_ram_d), .ram_wem(b_ram_wem),
    .ram_we(b_ram_we), .ram_me(b_ram_me), .ram_oe(b_ram_oe), .ram_q(b_ram_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Apply one cycle of A stimulus just after the edge, settle before checks
  task automatic drive(input logic iv, input logic [11:0] ia, input logic dv, input logic dwe,
                       input logic [11:0] da, input logic [31:0] dwd, input logic [3:0] dm);
    @(posedge CLK);
    #1;
    a_iv = iv; a_ia = ia; a_dv = dv; a_dwe = dwe; a_da = da; a_dwd = dwd; a_dm = dm;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
  endtask

  initial begin
    a_iv = 1'b0; a_ia = 12'h0; a_dv = 1'b0; a_dwe = 1'b0; a_da = 12'h0; a_dwd = 32'h0; a_dm = 4'h0;
    b_iv = 1'b0; b_dv = 1'b0;
    #3;
    chk("rst_i_ready", {31'h0, a_ir}, 32'h0);
    chk("rst_ram_me", {31'h0, a_ram_me}, 32'h0);
    chk("rst_ram_oe", {31'h0, a_ram_oe}, 32'h1);
    chk("rst_rsp", {30'h0, a_irv, a_drv}, 32'h0);
    @(posedge CLK); @(posedge CLK); #1 RST_N = 1'b1;

    // Preload through the D write port
    drive(1'b0, 12'h0, 1'b1, 1'b1, 12'h000, 32'h12345678, 4'hF);
    chk("wr_d_ready", {31'h0, a_dr}, 32'h1);
    chk("wr_ram_we", {31'h0, a_ram_we}, 32'h1);
    chk("wr_ram_adr", {20'h0, a_ram_adr}, 32'h000);
    drive(1'b0, 12'h0, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
    chk("wr_no_rsp", {30'h0, a_irv, a_drv}, 32'h0);
    drive(1'b0, 12'h0, 1'b1, 1'b1, 12'h020, 32'hAAAAAAAA, 4'hF);
    drive(1'b0, 12'h0, 1'b1, 1'b1, 12'hFFF, 32'h5A5A5A5A, 4'hF);
    idle();
    chk("idle_ram_me", {31'h0, a_ram_me}, 32'h0);
    chk("idle_ready", {30'h0, a_ir, a_dr}, 32'h0);

    // Single I read
    drive(1'b1, 12'h010, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    chk("ird_ready", {31'h0, a_ir}, 32'h1);
    chk("ird_ram_we", {27'h0, a_ram_wem, a_ram_we}, 32'h0);
    chk("ird_ram_adr", {20'h0, a_ram_adr}, 32'h010);
    idle();
    chk("ird_rsp_valid", {30'h0, a_irv, a_drv}, 32'h2);
    chk("ird_rsp_data", a_ird, 32'hDEADBEEF);

    // Byte write then read-after-write
    drive(1'b0, 12'h0, 1'b1, 1'b1, 12'h020, 32'h11223344, 4'b0101);
    chk("bw_ram_wem", {28'h0, a_ram_wem}, 32'h5);
    drive(1'b0, 12'h0, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
    chk("bw_no_rsp", {30'h0, a_irv, a_drv}, 32'h0);
    idle();
    chk("raw_rsp_valid", {30'h0, a_irv, a_drv}, 32'h1);
    chk("raw_rsp_data", a_drd, 32'hAA22AA44);

    // Address extremes
    drive(1'b1, 12'hFFF, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    drive(1'b1, 12'h000, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    chk("wrap_fff", a_ird, 32'h5A5A5A5A);
    idle();
    chk("wrap_000", a_ird, 32'h12345678);

    // Round-robin contention: last grant was I, so D leads
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 12'h010, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
      chk($sformatf("rr_gnt%0d", k), {30'h0, a_dr, a_ir}, (k % 2 == 0) ? 32'h2 : 32'h1);
      if (k > 0) begin
        if ((k - 1) % 2 == 0) begin
          chk($sformatf("rr_rsp%0d", k), {a_drv, a_irv, a_drd[29:0]}, {2'b10, 30'h2A22AA44});
        end else begin
          chk($sformatf("rr_rsp%0d", k), {a_drv, a_irv, a_ird[29:0]}, {2'b01, 30'h1EADBEEF});
        end
      end
    end
    idle();
    chk("rr_rsp_last", {a_drv, a_irv, a_ird[29:0]}, {2'b01, 30'h1EADBEEF});

    // Reset while an I read is in flight
    drive(1'b1, 12'h010, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    chk("rf_ready", {31'h0, a_ir}, 32'h1);
    @(posedge CLK);
    #1 RST_N = 1'b0;
    a_iv = 1'b0;
    #1;
    chk("rf_rsp_in_rst", {30'h0, a_irv, a_drv}, 32'h0);
    @(posedge CLK); #1 RST_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle();
      chk($sformatf("rf_post%0d", k), {29'h0, a_irv, a_drv, a_ram_me}, 32'h0);
    end

    // Starvation guard on the fixed-priority instance
    for (int k = 0; k < 7; k++) begin
      @(posedge CLK);
      #1 b_iv = 1'b1; b_dv = 1'b1;
      #2;
      chk($sformatf("fp_gnt%0d", k), {30'h0, b_dr, b_ir}, (k == 3) ? 32'h1 : 32'h2);
    end
    @(posedge CLK);
    #1 b_iv = 1'b0; b_dv = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
